uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Sequencing controller for the UART receiver. It detects the start edge and runs the 8x-oversampling edge counter and bit counter. It drives the enables for the data sampler, deserializer and start/parity/stop checkers, and issues a one-cycle `data_valid` for each error-free frame. It sits between the synchronized serial input and the RX datapath sub-blocks (sampler, deserializer, checkers).

## Interface
- `DATA_WIDTH`, default 8: data bits per frame (1..15).
- `CLK` input 1: oversampling clock, 8x baud.
- `RST` input 1: reset, asynchronous, active-low.
- `RX_IN` input 1: synchronized serial line, idle high.
- `PAR_EN` input 1: parity bit present in frame; must be static while not IDLE.
- `sampled_bit` input 1: majority-voted bit from sampler, valid at edge 6 and edge 7.
- `strt_glitch` input 1: start checker result, valid at START edge 7.
- `par_err` input 1: parity checker result, valid at PARITY edge 7.
- `stp_err` input 1: stop checker result, valid at STOP edge 7.
- `edge_count` output 3: oversampling edge index 0..7.
- `bit_count` output 4: bit index within the current phase.
- `dat_samp_en` output 1: sampler enable.
- `deser_en` output 1: deserializer enable; the deserializer shifts when this is high and `edge_count`==7.
- `strt_chk_en`, `par_chk_en`, `stp_chk_en` output 1 each: checker enables.
- `data_valid` output 1: one-cycle pulse when a good frame completes.
- `par_error`, `frame_error` output 1 each: sticky error flags for the last frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE
  - `edge_count` and `bit_count` are held at 0.
  - `RX_IN`==0 moves to START.
- Edge counter
  - Increments every cycle outside IDLE and DONE, wrapping 7→0.
  - `bit_count` increments on each wrap within DATA.
  - `bit_count` clears to 0 on every state change.
- START
  - `strt_chk_en`=1 at edge 7.
  - At edge 7, if `strt_glitch`=1 the controller returns to IDLE; no flags are set.
  - At edge 7, if `strt_glitch`=0 it moves to DATA.
- DATA
  - `deser_en`=1 for the whole state.
  - At edge 7 with `bit_count`==DATA_WIDTH-1, moves to PARITY if `PAR_EN`=1, else to STOP.
- PARITY
  - `par_chk_en`=1 at edge 7.
  - `par_err` is latched into `par_error`.
  - Moves to STOP.
- STOP
  - `stp_chk_en`=1 at edge 7.
  - `stp_err` is latched into `frame_error`.
  - Moves to DONE if neither error is set (counting the error latched this cycle), else to IDLE.
- DONE
  - `data_valid`=1.
  - `RX_IN`==0 moves to START (back-to-back frame), else to IDLE.
- Oversampling enables
  - `dat_samp_en`=1 in START, DATA, PARITY and STOP.
- Error flags
  - `par_error` and `frame_error` hold until the next START entry, where both clear.
- Reset
  - Asserting `RST` at any time, including mid-frame, forces IDLE immediately.
  - The partial frame is discarded; no `data_valid` is issued.

## Timing
- Reset values:
  - state IDLE.
  - `edge_count`=0, `bit_count`=0.
  - All enables 0, `data_valid`=0, `par_error`=0, `frame_error`=0.
- All outputs are decoded from registered state and counters; there is no combinational path from `RX_IN` to any output.
- `RX_IN` is low at cycle t, so START is entered at t+1 with `edge_count`=0.
- With parity:
  - START edge 7 at t+8.
  - Last DATA edge 7 at t+72.
  - PARITY edge 7 at t+80.
  - STOP edge 7 at t+88.
  - `data_valid` at t+89.
- Without parity: STOP edge 7 at t+80, `data_valid` at t+81.
- `data_valid` is exactly one cycle wide, and P_DATA is stable during it.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state exists and `PAR_EN` is honoured.
  - `par_chk_en` and `par_error` are functional.
- `UART_RX_PARITY_EN` undefined:
  - The PARITY state is removed; DATA always moves to STOP.
  - `PAR_EN` and `par_err` are ignored.
  - `par_chk_en` and `par_error` are tied to 0.
  - All ports remain present.

## Structure
- Package `uart_rx_pkg`:
  - State enum.
  - `PRESCALE`=8, `EDGE_W`=3, `SAMPLE_EDGE`=7.
- Sub-module `uart_rx_edge_bit_counter`:
  - Edge and bit counters with enable, clear and wrap output.
- The FSM, enable decode and error flags stay in `uart_rx_ctrl`.

## Test plan
- **Good frame, parity:** 0xA5 framed with even parity, `PAR_EN`=1, checkers clean → `deser_en` high for 64 cycles, `data_valid` high at t+89, both error flags 0.
- **Parity error:** 0x3C with `par_err` forced 1 at PARITY edge 7 → `par_error`=1, no `data_valid`, back to IDLE after STOP.
- **Start glitch:** `RX_IN` low for 3 cycles only, `strt_glitch`=1 at edge 7 → IDLE at t+9, no enables beyond START, flags unchanged.
- **Framing error:** `PAR_EN`=0, `stp_err`=1 at STOP edge 7 (t+80) → `frame_error`=1, no `data_valid`.
- **Back-to-back frames:** 0x3C then 0xC3, with the next start bit low in the DONE cycle → START re-entered without passing through IDLE, two `data_valid` pulses 89 cycles apart.
- **Reset mid-frame:** `RST` low during DATA with `bit_count`=4 → immediate IDLE, all outputs at reset values; the next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller and its counter.
// The optional parity phase is selected by the UART_RX_PARITY_EN macro.
package uart_rx_pkg;

  localparam int PRESCALE = 8;
  localparam int EDGE_W   = 3;
  localparam int BIT_W    = 4;

  localparam logic [EDGE_W-1:0] SAMPLE_EDGE = EDGE_W'(PRESCALE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } uart_rx_state_e;

  // Phases where the line is being oversampled and the counters run.
  function automatic logic is_frame_phase(input uart_rx_state_e s);
    return (s == START) || (s == DATA) || (s == PARITY) || (s == STOP);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the RX sequencing controller (master) and the RX
// datapath: serial input, checker results, counters, enables and status.
interface uart_rx_ctrl_if;
  import uart_rx_pkg::*;

  logic              RX_IN;
  logic              PAR_EN;
  logic              sampled_bit;
  logic              strt_glitch;
  logic              par_err;
  logic              stp_err;

  logic [EDGE_W-1:0] edge_count;
  logic [BIT_W-1:0]  bit_count;
  logic              dat_samp_en;
  logic              deser_en;
  logic              strt_chk_en;
  logic              par_chk_en;
  logic              stp_chk_en;
  // data_valid is a one-cycle strobe with no ready: the consumer must take the
  // frame in that exact cycle; there is no backpressure and no retry.
  logic              data_valid;
  logic              par_error;
  logic              frame_error;

  modport master (
    input  RX_IN, PAR_EN, sampled_bit, strt_glitch, par_err, stp_err,
    output edge_count, bit_count, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, par_error, frame_error
  );

  modport slave (
    output RX_IN, PAR_EN, sampled_bit, strt_glitch, par_err, stp_err,
    input  edge_count, bit_count, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, par_error, frame_error
  );

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter (0..PRESCALE-1) and per-phase bit counter.
// Clear has priority over count; wrap marks the last edge of a bit period.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              clr,
  input  logic              bit_en,
  output logic [EDGE_W-1:0] edge_count,
  output logic [BIT_W-1:0]  bit_count,
  output logic              wrap
);

  assign wrap = en && (edge_count == SAMPLE_EDGE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (clr) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (en) begin
      edge_count <= wrap ? '0 : edge_count + 1'b1;
      if (wrap && bit_en) begin
        bit_count <= bit_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX sequencing controller: start detection, phase FSM, datapath enables
// and sticky error flags. Define UART_RX_PARITY_EN to build the parity phase.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_rx_ctrl_if.master bus,
  output uart_rx_state_e state_dbg
);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  uart_rx_state_e    state;
  uart_rx_state_e    next_state;
  logic [EDGE_W-1:0] edge_count;
  logic [BIT_W-1:0]  bit_count;
  logic              wrap;
  logic              cnt_en;
  logic              cnt_clr;
  logic              start_entry;
  logic              par_on;
  logic              par_error_q;
  logic              frame_error_q;
  logic              unused_in;

  logic              dat_samp_en;
  logic              deser_en;
  logic              strt_chk_en;
  logic              par_chk_en;
  logic              stp_chk_en;
  logic              data_valid;

  assign cnt_en  = is_frame_phase(state);
  // Counters restart on every phase change so each phase begins at edge 0, bit 0.
  assign cnt_clr = (next_state != state) || (state == IDLE);

  uart_rx_edge_bit_counter u_counter (
    .CLK        (CLK),
    .RST        (RST),
    .en         (cnt_en),
    .clr        (cnt_clr),
    .bit_en     (state == DATA),
    .edge_count (edge_count),
    .bit_count  (bit_count),
    .wrap       (wrap)
  );

`ifdef UART_RX_PARITY_EN
  assign par_on    = bus.PAR_EN;
  assign unused_in = bus.sampled_bit;
`else
  assign par_on    = 1'b0;
  assign unused_in = ^{bus.sampled_bit, bus.PAR_EN, bus.par_err};
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.RX_IN) next_state = START;
      end
      START: begin
        dat_samp_en = 1'b1;
        strt_chk_en = (edge_count == SAMPLE_EDGE);
        if (wrap) next_state = bus.strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        dat_samp_en = 1'b1;
        deser_en    = 1'b1;
        if (wrap && (bit_count == LAST_BIT)) next_state = par_on ? PARITY : STOP;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        dat_samp_en = 1'b1;
        par_chk_en  = (edge_count == SAMPLE_EDGE);
        if (wrap) next_state = STOP;
      end
`endif
      STOP: begin
        dat_samp_en = 1'b1;
        stp_chk_en  = (edge_count == SAMPLE_EDGE);
        // The stop result is folded in directly since it is only latched at this edge.
        if (wrap) next_state = (par_error_q || bus.stp_err) ? IDLE : DONE;
      end
      DONE: begin
        data_valid = 1'b1;
        next_state = bus.RX_IN ? IDLE : START;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign start_entry = (next_state == START) && (state != START);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frame_error_q <= 1'b0;
    end else if (start_entry) begin
      frame_error_q <= 1'b0;
    end else if ((state == STOP) && wrap) begin
      frame_error_q <= bus.stp_err;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_error_q <= 1'b0;
    end else if (start_entry) begin
      par_error_q <= 1'b0;
    end else if ((state == PARITY) && wrap) begin
      par_error_q <= bus.par_err;
    end
  end
`else
  assign par_error_q = 1'b0;
`endif

  assign bus.edge_count  = edge_count;
  assign bus.bit_count   = bit_count;
  assign bus.dat_samp_en = dat_samp_en;
  assign bus.deser_en    = deser_en;
  assign bus.strt_chk_en = strt_chk_en;
  assign bus.par_chk_en  = par_chk_en;
  assign bus.stp_chk_en  = stp_chk_en;
  assign bus.data_valid  = data_valid;
  assign bus.par_error   = par_error_q;
  assign bus.frame_error = frame_error_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: frame driver, data_valid scoreboard
// keyed on expected cycle, and one task per scenario.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  localparam int DW = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_rx_state_e state_dbg;
  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_cyc;
  int checks = 0;
  int errors = 0;

  always @(negedge CLK) begin
    if (RST && bus.data_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dv_unexpected: data_valid at cycle %0d, none expected", cyc);
      end else begin
        exp_cyc = exp_q.pop_front();
        if (32'(cyc) !== exp_cyc) begin
          errors++;
          $display("FAIL dv_cycle: data_valid at cycle %0d, expected cycle %0d", cyc, exp_cyc);
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------- frame driver ----------------
  int deser_cnt, samp_cnt, strt_k, par_k, stp_k;
  logic [EDGE_W-1:0] ec_mid;
  logic [BIT_W-1:0]  bc_mid;
  uart_rx_state_e    st_k0, st_k1;

  function automatic int stop_k_of(input bit par_en);
    return 8 + DW * 8 + ((PAR_BUILD && par_en) ? 8 : 0) + 8;
  endfunction

  function automatic logic line_bit(input int k, input logic [14:0] data,
                                    input bit par_on, input bit glitch);
    if (glitch) return (k < 3) ? 1'b0 : 1'b1;
    if (k < 8) return 1'b0;
    if (k < 8 + DW * 8) return data[(k - 8) / 8];
    if (par_on && (k < 16 + DW * 8)) return ^data[DW-1:0];
    return 1'b1;
  endfunction

  // Called and returns just after a rising edge. Cycle k=0 is the cycle RX_IN
  // first goes low; checker results are driven only in their sampling cycle.
  task automatic run_frame(input logic [14:0] data, input bit par_en, input bit glitch,
                           input bit perr, input bit serr, input int abort_k,
                           output int t0);
    int  stop_k, last_k, par_edge;
    bit  par_on;
    par_on   = PAR_BUILD && par_en;
    stop_k   = stop_k_of(par_en);
    par_edge = 8 + DW * 8 + 8;
    last_k   = glitch ? 8 : stop_k;
    deser_cnt = 0; samp_cnt = 0; strt_k = -1; par_k = -1; stp_k = -1;
    ec_mid = '0; bc_mid = '0; st_k0 = IDLE; st_k1 = IDLE;
    t0 = cyc;
    bus.PAR_EN = par_en;
    if ((abort_k < 0) && !glitch && !(par_on && perr) && !serr)
      exp_q.push_back(32'(t0 + stop_k + 1));
    for (int k = 0; k <= last_k; k++) begin
      if (k == abort_k) return;
      bus.RX_IN       = line_bit(k, data, par_on, glitch);
      bus.sampled_bit = bus.RX_IN;
      bus.strt_glitch = glitch && (k == 8);
      bus.par_err     = perr && (k == par_edge);
      bus.stp_err     = serr && (k == stop_k);
      @(negedge CLK);
      if (bus.deser_en)    deser_cnt++;
      if (bus.dat_samp_en) samp_cnt++;
      if (bus.strt_chk_en) strt_k = k;
      if (bus.par_chk_en)  par_k = k;
      if (bus.stp_chk_en)  stp_k = k;
      if (k == 0) st_k0 = state_dbg;
      if (k == 1) st_k1 = state_dbg;
      if (k == 37) begin ec_mid = bus.edge_count; bc_mid = bus.bit_count; end
      @(posedge CLK); #1;
    end
    bus.strt_glitch = 1'b0;
    bus.par_err     = 1'b0;
    bus.stp_err     = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    bus.RX_IN = 1'b1; bus.sampled_bit = 1'b1;
    bus.strt_glitch = 1'b0; bus.par_err = 1'b0; bus.stp_err = 1'b0;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  function automatic logic [7:0] outs();
    return {bus.dat_samp_en, bus.deser_en, bus.strt_chk_en, bus.par_chk_en,
            bus.stp_chk_en, bus.data_valid, bus.par_error, bus.frame_error};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b0;
    bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.sampled_bit = 1'b1;
    bus.strt_glitch = 1'b0; bus.par_err = 1'b0; bus.stp_err = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (state_dbg !== IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", state_dbg, IDLE); end
    checks++;
    if (bus.edge_count !== 3'd0) begin errors++; $display("FAIL rst_edge: got %0d expected 0", bus.edge_count); end
    checks++;
    if (bus.bit_count !== 4'd0) begin errors++; $display("FAIL rst_bit: got %0d expected 0", bus.bit_count); end
    checks++;
    if (outs() !== 8'h00) begin errors++; $display("FAIL rst_outs: got %b expected 00000000", outs()); end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (state_dbg !== IDLE) begin errors++; $display("FAIL idle_hold: got %0d expected %0d", state_dbg, IDLE); end
    @(posedge CLK); #1;
  endtask

  task automatic test_good_frame();
    int t0, sk;
    sk = stop_k_of(1'b1);
    run_frame(15'h0A5, 1'b1, 1'b0, 1'b0, 1'b0, -1, t0);
    @(negedge CLK);
    checks++;
    if (state_dbg !== DONE) begin errors++; $display("FAIL good_done: got %0d expected %0d", state_dbg, DONE); end
    checks++;
    if (deser_cnt !== DW * 8) begin errors++; $display("FAIL good_deser: got %0d expected %0d", deser_cnt, DW * 8); end
    checks++;
    if (samp_cnt !== sk) begin errors++; $display("FAIL good_samp: got %0d expected %0d", samp_cnt, sk); end
    checks++;
    if (strt_k !== 8) begin errors++; $display("FAIL good_strt_chk: got %0d expected 8", strt_k); end
    checks++;
    if (stp_k !== sk) begin errors++; $display("FAIL good_stp_chk: got %0d expected %0d", stp_k, sk); end
    checks++;
    if (par_k !== (PAR_BUILD ? 80 : -1)) begin errors++; $display("FAIL good_par_chk: got %0d expected %0d", par_k, PAR_BUILD ? 80 : -1); end
    checks++;
    if ({ec_mid, bc_mid} !== {3'd4, 4'd3}) begin errors++; $display("FAIL good_counters: got edge %0d bit %0d expected edge 4 bit 3", ec_mid, bc_mid); end
    checks++;
    if (st_k0 !== IDLE || st_k1 !== START) begin errors++; $display("FAIL good_entry: got %0d,%0d expected %0d,%0d", st_k0, st_k1, IDLE, START); end
    checks++;
    if ({bus.par_error, bus.frame_error} !== 2'b00) begin errors++; $display("FAIL good_flags: got %b expected 00", {bus.par_error, bus.frame_error}); end
    @(posedge CLK); #1;
    idle_cycles(4);
  endtask

  task automatic test_start_glitch();
    int t0;
    run_frame(15'h000, 1'b1, 1'b1, 1'b0, 1'b0, -1, t0);
    @(negedge CLK);
    checks++;
    if (state_dbg !== IDLE) begin errors++; $display("FAIL glitch_idle: got %0d expected %0d", state_dbg, IDLE); end
    checks++;
    if (samp_cnt !== 8 || deser_cnt !== 0) begin errors++; $display("FAIL glitch_enables: got samp %0d deser %0d expected 8 0", samp_cnt, deser_cnt); end
    checks++;
    if (strt_k !== 8 || stp_k !== -1) begin errors++; $display("FAIL glitch_chk: got strt %0d stp %0d expected 8 -1", strt_k, stp_k); end
    checks++;
    if ({bus.par_error, bus.frame_error} !== 2'b00) begin errors++; $display("FAIL glitch_flags: got %b expected 00", {bus.par_error, bus.frame_error}); end
    @(posedge CLK); #1;
    idle_cycles(4);
  endtask

  task automatic test_parity_error();
    int t0;
    run_frame(15'h03C, 1'b1, 1'b0, 1'b1, 1'b0, -1, t0);
    @(negedge CLK);
    checks++;
    if (state_dbg !== (PAR_BUILD ? IDLE : DONE)) begin errors++; $display("FAIL perr_state: got %0d expected %0d", state_dbg, PAR_BUILD ? IDLE : DONE); end
    checks++;
    if (bus.par_error !== PAR_BUILD) begin errors++; $display("FAIL perr_flag: got %b expected %b", bus.par_error, PAR_BUILD); end
    checks++;
    if (bus.frame_error !== 1'b0) begin errors++; $display("FAIL perr_frame: got %b expected 0", bus.frame_error); end
    @(posedge CLK); #1;
    idle_cycles(6);
    @(negedge CLK);
    checks++;
    if (bus.par_error !== PAR_BUILD) begin errors++; $display("FAIL perr_sticky: got %b expected %b", bus.par_error, PAR_BUILD); end
    @(posedge CLK); #1;
  endtask

  task automatic test_framing_error();
    int t0;
    run_frame(15'h05A, 1'b0, 1'b0, 1'b0, 1'b1, -1, t0);
    @(negedge CLK);
    checks++;
    if (stp_k !== 80) begin errors++; $display("FAIL ferr_stp_chk: got %0d expected 80", stp_k); end
    checks++;
    if (state_dbg !== IDLE) begin errors++; $display("FAIL ferr_state: got %0d expected %0d", state_dbg, IDLE); end
    checks++;
    if ({bus.par_error, bus.frame_error} !== 2'b01) begin errors++; $display("FAIL ferr_flags: got %b expected 01", {bus.par_error, bus.frame_error}); end
    @(posedge CLK); #1;
    idle_cycles(5);
    @(negedge CLK);
    checks++;
    if (bus.frame_error !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b expected 1", bus.frame_error); end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    int t0a, t0b;
    run_frame(15'h03C, 1'b1, 1'b0, 1'b0, 1'b0, -1, t0a);
    run_frame(15'h0C3, 1'b1, 1'b0, 1'b0, 1'b0, -1, t0b);
    @(negedge CLK);
    checks++;
    if (st_k0 !== DONE || st_k1 !== START) begin errors++; $display("FAIL b2b_entry: got %0d,%0d expected %0d,%0d", st_k0, st_k1, DONE, START); end
    checks++;
    if (deser_cnt !== DW * 8) begin errors++; $display("FAIL b2b_deser: got %0d expected %0d", deser_cnt, DW * 8); end
    checks++;
    if (state_dbg !== DONE) begin errors++; $display("FAIL b2b_done: got %0d expected %0d", state_dbg, DONE); end
    checks++;
    if (bus.frame_error !== 1'b0) begin errors++; $display("FAIL b2b_flag_clear: got %b expected 0", bus.frame_error); end
    @(posedge CLK); #1;
    idle_cycles(4);
  endtask

  task automatic test_reset_mid_frame();
    int t0;
    run_frame(15'h0F0, 1'b1, 1'b0, 1'b0, 1'b0, 46, t0);
    @(negedge CLK);
    checks++;
    if (state_dbg !== DATA || bus.bit_count !== 4'd4) begin errors++; $display("FAIL mid_pre: got state %0d bit %0d expected %0d 4", state_dbg, bus.bit_count, DATA); end
    #2 RST = 1'b0;
    #1;
    checks++;
    if (state_dbg !== IDLE) begin errors++; $display("FAIL mid_rst_state: got %0d expected %0d", state_dbg, IDLE); end
    checks++;
    if ({bus.edge_count, bus.bit_count} !== 7'd0) begin errors++; $display("FAIL mid_rst_counters: got edge %0d bit %0d expected 0 0", bus.edge_count, bus.bit_count); end
    checks++;
    if (outs() !== 8'h00) begin errors++; $display("FAIL mid_rst_outs: got %b expected 00000000", outs()); end
    bus.RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    idle_cycles(2);
    run_frame(15'h096, 1'b1, 1'b0, 1'b0, 1'b0, -1, t0);
    @(negedge CLK);
    checks++;
    if (state_dbg !== DONE || deser_cnt !== DW * 8) begin errors++; $display("FAIL mid_next_frame: got state %0d deser %0d expected %0d %0d", state_dbg, deser_cnt, DONE, DW * 8); end
    @(posedge CLK); #1;
    idle_cycles(4);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_start_glitch();
    test_parity_error();
    test_framing_error();
    test_back_to_back();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL dv_missing: %0d expected data_valid pulses never seen, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
